// File: rtl/encoder_pkg.sv
// Shared step indices, state encoding and mask helpers for the encoder round sequencer.
package encoder_pkg;

  localparam int NUM_STEPS = 5;

  localparam int STEP_CP = 0;
  localparam int STEP_RO = 1;
  localparam int STEP_PE = 2;
  localparam int STEP_RE = 3;
  localparam int STEP_RC = 4;

  typedef logic [NUM_STEPS-1:0] step_mask_t;
  typedef logic [2:0]           step_idx_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Lowest enabled step; 0 for an empty mask (caller never issues in that case).
  function automatic step_idx_t f_first_step(input step_mask_t mask);
    f_first_step = '0;
    for (int i = NUM_STEPS - 1; i >= 0; i--) begin
      if (mask[i]) f_first_step = step_idx_t'(i);
    end
  endfunction

endpackage

// File: rtl/encoder_step_sel.sv
// Combinational step selector: next enabled step above the pointer, last-in-round flag,
// and first enabled step of the round.
module encoder_step_sel
  import encoder_pkg::*;
(
  input  step_mask_t i_mask,
  input  step_idx_t  i_ptr,
  output step_idx_t  o_next,
  output logic       o_last,
  output step_idx_t  o_first
);

  // Scan downward so the closest enabled step above the pointer wins.
  always_comb begin
    o_next = i_ptr;
    o_last = 1'b1;
    for (int i = NUM_STEPS - 1; i >= 0; i--) begin
      if (i_mask[i] && (step_idx_t'(i) > i_ptr)) begin
        o_next = step_idx_t'(i);
        o_last = 1'b0;
      end
    end
  end

  assign o_first = f_first_step(i_mask);

endmodule

// File: rtl/encoder_round_sequencer.sv
// Walks a batch of files through NUM_ROUNDS rounds of the enabled encoder steps,
// one-hot start / per-step finish handshake, with abort and a per-step watchdog.
module encoder_round_sequencer
  import encoder_pkg::*;
#(
  parameter int NUM_ROUNDS     = 24,
  parameter int FILE_IDX_W     = 10,
  parameter int ITER_W         = 5,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [FILE_IDX_W-1:0] i_file_base,
  input  logic [FILE_IDX_W-1:0] i_file_count,
  input  logic [NUM_STEPS-1:0]  i_step_mask,
  input  logic [NUM_STEPS-1:0]  i_step_finish,
  output logic [NUM_STEPS-1:0]  o_step_start,
  output logic [FILE_IDX_W-1:0] o_file_index,
  output logic [ITER_W-1:0]     o_iteration,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

  state_t                r_state;
  step_mask_t            r_mask;
  step_idx_t             r_ptr;
  logic [FILE_IDX_W-1:0] r_files_left;
  logic [TW-1:0]         r_timer;

  step_idx_t     w_next;
  step_idx_t     w_first;
  step_idx_t     w_first_in;
  logic          w_last_step;
  logic          w_last_iter;
  logic          w_more_files;
  logic          w_empty_batch;
  logic [TW-1:0] w_timer_nxt;
  logic          w_expire;

  encoder_step_sel u_step_sel (
    .i_mask  (r_mask),
    .i_ptr   (r_ptr),
    .o_next  (w_next),
    .o_last  (w_last_step),
    .o_first (w_first)
  );

  assign w_first_in    = f_first_step(i_step_mask);
  assign w_empty_batch = (i_file_count == '0) || (i_step_mask == '0);
  assign w_last_iter   = (o_iteration == ITER_W'(NUM_ROUNDS - 1));
  assign w_more_files  = (r_files_left > FILE_IDX_W'(1));
  assign w_timer_nxt   = r_timer + TW'(1);
  assign w_expire      = (TIMEOUT_CYCLES != 0) && (32'(w_timer_nxt) == TIMEOUT_CYCLES);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_mask       <= '0;
      r_ptr        <= '0;
      r_files_left <= '0;
      r_timer      <= '0;
      o_step_start <= '0;
      o_file_index <= '0;
      o_iteration  <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_timeout    <= 1'b0;
    end else if (i_abort && (r_state != ST_IDLE)) begin
      // Abort beats any finish or watchdog expiry in the same cycle.
      r_state      <= ST_IDLE;
      o_step_start <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_mask       <= i_step_mask;
            r_files_left <= i_file_count;
            r_ptr        <= w_first_in;
            o_file_index <= i_file_base;
            o_iteration  <= '0;
            o_timeout    <= 1'b0;
            o_busy       <= 1'b1;
            if (w_empty_batch) begin
              r_state <= ST_DONE;
              o_done  <= 1'b1;
            end else begin
              r_state      <= ST_ISSUE;
              o_step_start <= step_mask_t'(1) << w_first_in;
            end
          end
        end

        ST_ISSUE: begin
          o_step_start <= '0;
          r_timer      <= '0;
          r_state      <= ST_WAIT;
        end

        ST_WAIT: begin
          if (i_step_finish[r_ptr]) begin
            if (!w_last_step) begin
              r_ptr        <= w_next;
              o_step_start <= step_mask_t'(1) << w_next;
              r_state      <= ST_ISSUE;
            end else if (!w_last_iter) begin
              o_iteration  <= o_iteration + ITER_W'(1);
              r_ptr        <= w_first;
              o_step_start <= step_mask_t'(1) << w_first;
              r_state      <= ST_ISSUE;
            end else if (w_more_files) begin
              o_file_index <= o_file_index + FILE_IDX_W'(1);
              r_files_left <= r_files_left - FILE_IDX_W'(1);
              o_iteration  <= '0;
              r_ptr        <= w_first;
              o_step_start <= step_mask_t'(1) << w_first;
              r_state      <= ST_ISSUE;
            end else begin
              o_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end else begin
            r_timer <= w_timer_nxt;
            if (w_expire) begin
              o_timeout <= 1'b1;
              o_done    <= 1'b1;
              r_state   <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_round_sequencer.sv
// Randomized bench: expected step sequence built from nested file/round/step loops,
// finishes returned by a delayed responder, timing checked against per-step cost.
module tb_encoder_round_sequencer;

  localparam int NR = 3;
  localparam int FW = 10;
  localparam int IW = 5;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [FW-1:0] base;
  logic [FW-1:0] cnt;
  logic [4:0]    mask;
  logic [4:0]    fin;
  logic [4:0]    sstart;
  logic [FW-1:0] fidx;
  logic [IW-1:0] iter;
  logic          busy;
  logic          done;
  logic          tout;

  always #5 clk = ~clk;

  encoder_round_sequencer #(
    .NUM_ROUNDS     (NR),
    .FILE_IDX_W     (FW),
    .ITER_W         (IW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_abort       (abort),
    .i_file_base   (base),
    .i_file_count  (cnt),
    .i_step_mask   (mask),
    .i_step_finish (fin),
    .o_step_start  (sstart),
    .o_file_index  (fidx),
    .o_iteration   (iter),
    .o_busy        (busy),
    .o_done        (done),
    .o_timeout     (tout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int step;
    int file;
    int iter;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_start"}, sstart, 0);
    check({tag, "_file"},  fidx,   0);
    check({tag, "_iter"},  iter,   0);
    check({tag, "_busy"},  busy,   0);
    check({tag, "_done"},  done,   0);
    check({tag, "_tout"},  tout,   0);
  endtask

  // fixd: fixed finish delay (0 = random 1..8); abort_at: ordinal of the step whose
  // finish carries abort (-1 none); noise: junk finish bits, start and config while busy;
  // stall: never finish the first step.
  task automatic run_batch(input int b, input int n, input int m, input int fixd,
                           input int abort_at, input bit noise, input bit stall);
    exp_t e;
    int c, exp_done, pend_cyc, pend_step, pend_file, pend_iter, pend_ord;
    int last_fin, ord, ca, ndone, d;
    bit aborted, closed, to_case;

    exp_q.delete();
    for (int f = 0; f < n; f++)
      for (int r = 0; r < NR; r++)
        for (int s = 0; s < 5; s++)
          if (((m >> s) & 1) != 0) exp_q.push_back('{s, (b + f) % (1 << FW), r});

    exp_done  = (exp_q.size() == 0) ? 1 : -1;
    pend_cyc  = -1;
    pend_step = 0;
    pend_file = 0;
    pend_iter = 0;
    pend_ord  = -1;
    last_fin  = 0;
    ord       = 0;
    ca        = -1;
    ndone     = 0;
    aborted   = 1'b0;
    closed    = 1'b0;
    to_case   = 1'b0;

    start = 1'b1;
    base  = FW'(b);
    cnt   = FW'(n);
    mask  = 5'(m);
    fin   = '0;
    abort = 1'b0;
    c     = 0;

    while (c < 2000) begin
      @(posedge clk);
      #1;
      c++;

      if (sstart != 0) begin
        if (exp_q.size() == 0 || closed) begin
          check("extra_start", sstart, 0);
        end else begin
          e = exp_q.pop_front();
          check("start_step",  sstart, 1 << e.step);
          check("start_cycle", c,      last_fin + 1);
          check("start_file",  fidx,   e.file);
          check("start_iter",  iter,   e.iter);
          pend_step = e.step;
          pend_file = e.file;
          pend_iter = e.iter;
          pend_ord  = ord;
          if (stall && ord == 0) begin
            pend_cyc = -1;
            exp_done = c + 1 + TO;
            to_case  = 1'b1;
            closed   = 1'b1;
          end else begin
            d = (fixd != 0) ? fixd : $urandom_range(1, 8);
            pend_cyc = c + d;
          end
          ord++;
        end
      end

      if (done) begin
        ndone++;
        check("done_cycle", c, exp_done);
      end
      check("busy",    busy, (!aborted || c <= ca) && (exp_done < 0 || c <= exp_done));
      check("timeout", tout, to_case && c >= exp_done);

      start = 1'b0;
      fin   = '0;
      abort = 1'b0;
      if (noise) begin
        if (exp_done < 0 || c <= exp_done) start = 1'($urandom_range(0, 1));
        base = FW'($urandom);
        cnt  = FW'($urandom);
        mask = 5'($urandom);
        fin  = 5'($urandom) & ~5'(1 << pend_step);
      end
      if (c == pend_cyc) begin
        check("hold_file", fidx, pend_file);
        check("hold_iter", iter, pend_iter);
        fin      = fin | 5'(1 << pend_step);
        last_fin = c;
        pend_cyc = -1;
        if (pend_ord == abort_at) begin
          abort   = 1'b1;
          aborted = 1'b1;
          closed  = 1'b1;
          ca      = c;
        end else if (exp_q.size() == 0) begin
          exp_done = c + 1;
        end
      end

      if (ndone > 0 && exp_done >= 0 && c >= exp_done + 2) break;
      if (aborted && c >= ca + 4) break;
    end

    if (aborted) begin
      check("abort_done_cnt", ndone, 0);
    end else begin
      check("done_cnt", ndone, 1);
      if (!closed) check("steps_left", exp_q.size(), 0);
    end
    start = 1'b0;
    fin   = '0;
    abort = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    fin   = '0;
    base  = '0;
    cnt   = '0;
    mask  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    run_batch(7,    1, 5'b11111, 1, -1, 1'b0, 1'b0);
    run_batch(1022, 3, 5'b10010, 1, -1, 1'b0, 1'b0);
    run_batch(5,    0, 5'b11111, 1, -1, 1'b0, 1'b0);
    run_batch(5,    4, 5'b00000, 1, -1, 1'b0, 1'b0);
    run_batch(3,    2, 5'b11111, 1, -1, 1'b0, 1'b1);
    run_batch(9,    1, 5'b11111, 1,  7, 1'b0, 1'b0);
    run_batch(11,   2, 5'b11111, 1, -1, 1'b0, 1'b0);
    run_batch(7,    1, 5'b11111, 1, -1, 1'b1, 1'b0);
    repeat (12) begin
      run_batch(int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 31)), 0, -1, 1'b0, 1'b0);
    end
    run_batch(int'($urandom_range(0, 1023)), 2, int'($urandom_range(1, 31)), 0, -1, 1'b1, 1'b0);

    // Reset in the middle of a batch must drop everything without a done pulse.
    start = 1'b1;
    base  = 10'd4;
    cnt   = 10'd2;
    mask  = 5'b11111;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_zero("midrst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_idle_busy", busy, 0);
    check("midrst_idle_done", done, 0);
    run_batch(1000, 1, 5'b00100, 1, -1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
